// File: rtl/axis_upsizer.sv
// Purpose : AXI-Stream width upsizer. Packs N narrow words (N from cfg_data) into one wide beat.
// Latency : the wide beat is valid 1 cycle after its final narrow word is accepted.
// Backpres: non-final words are always accepted; the final word waits until the output register is free.
//
// Ports:
//   aclk, aresetn              clock (rising edge) and synchronous active-low reset
//   cfg_data[15:0]             words per beat minus one; only the low clog2(RATIO) bits are used
//   s_axis_tdata/tvalid/tready narrow slave stream
//   m_axis_tdata/tvalid/tready wide master stream
//   s_axis_tlast, m_axis_tlast only when AXIS_UPSIZER_TLAST_EN is defined; tlast ends a beat early
module axis_upsizer #(
    parameter int S_AXIS_TDATA_WIDTH = 32,
    parameter int M_AXIS_TDATA_WIDTH = 128
) (
    input  logic                          aclk,
    input  logic                          aresetn,
    input  logic [15:0]                   cfg_data,
    input  logic [S_AXIS_TDATA_WIDTH-1:0] s_axis_tdata,
    input  logic                          s_axis_tvalid,
    output logic                          s_axis_tready,
`ifdef AXIS_UPSIZER_TLAST_EN
    input  logic                          s_axis_tlast,
    output logic                          m_axis_tlast,
`endif
    output logic [M_AXIS_TDATA_WIDTH-1:0] m_axis_tdata,
    output logic                          m_axis_tvalid,
    input  logic                          m_axis_tready
);

    localparam int S          = S_AXIS_TDATA_WIDTH;
    localparam int RATIO      = M_AXIS_TDATA_WIDTH / S_AXIS_TDATA_WIDTH;
    localparam int CNTR_WIDTH = (RATIO > 1) ? $clog2(RATIO) : 1;
    localparam logic [CNTR_WIDTH-1:0] MAX_IDX = CNTR_WIDTH'(RATIO - 1);

    logic [CNTR_WIDTH-1:0]         cnt_q;      // lane of the next accepted word
    logic [CNTR_WIDTH-1:0]         nm1_q;      // N-1 latched at word 0 of the current beat
    logic [(RATIO-1)*S-1:0]        acc_q;      // words 0..N-2 of the current beat
    logic [M_AXIS_TDATA_WIDTH-1:0] out_q;
    logic                          out_vld_q;

    logic [CNTR_WIDTH-1:0]         cfg_lo;
    logic [CNTR_WIDTH-1:0]         cfg_nm1;
    logic [CNTR_WIDTH-1:0]         cur_nm1;
    logic                          last_in;
    logic                          final_word;
    logic                          accept;
    logic [M_AXIS_TDATA_WIDTH-1:0] pack;
    logic                          unused_cfg;

    assign cfg_lo     = cfg_data[CNTR_WIDTH-1:0];
    assign unused_cfg = ^cfg_data[15:CNTR_WIDTH];

    // Clamp so a non-power-of-two ratio can never overrun the lanes.
    assign cfg_nm1 = (cfg_lo > MAX_IDX) ? MAX_IDX : cfg_lo;

    // Word 0 uses live cfg_data; later words use the value latched at word 0.
    assign cur_nm1 = (cnt_q == '0) ? cfg_nm1 : nm1_q;

`ifdef AXIS_UPSIZER_TLAST_EN
    logic last_q;
    assign last_in      = s_axis_tlast;
    assign m_axis_tlast = last_q;
`else
    assign last_in = 1'b0;
`endif

    assign final_word = (cnt_q == cur_nm1) | last_in;

    // Only the final word needs room in the output register; it may enter
    // in the same cycle the pending beat drains, giving back-to-back beats.
    assign s_axis_tready = aresetn & (~final_word | ~out_vld_q | m_axis_tready);
    assign accept        = s_axis_tvalid & s_axis_tready;

    // Lanes below the counter come from the accumulator, the current word
    // goes into the counter's lane, everything above stays zero.
    always_comb begin
        pack = '0;
        for (int k = 0; k < RATIO - 1; k++) begin
            if (CNTR_WIDTH'(k) < cnt_q) begin
                pack[k*S +: S] = acc_q[k*S +: S];
            end
        end
        for (int k = 0; k < RATIO; k++) begin
            if (CNTR_WIDTH'(k) == cnt_q) begin
                pack[k*S +: S] = s_axis_tdata;
            end
        end
    end

    always_ff @(posedge aclk) begin
        if (!aresetn) begin
            cnt_q     <= '0;
            nm1_q     <= '0;
            acc_q     <= '0;
            out_q     <= '0;
            out_vld_q <= 1'b0;
`ifdef AXIS_UPSIZER_TLAST_EN
            last_q    <= 1'b0;
`endif
        end else begin
            if (accept && !final_word) begin
                for (int k = 0; k < RATIO - 1; k++) begin
                    if (CNTR_WIDTH'(k) == cnt_q) begin
                        acc_q[k*S +: S] <= s_axis_tdata;
                    end
                end
                if (cnt_q == '0) begin
                    nm1_q <= cfg_nm1;
                end
                cnt_q <= cnt_q + CNTR_WIDTH'(1);
            end

            if (accept && final_word) begin
                out_q     <= pack;
                out_vld_q <= 1'b1;
                cnt_q     <= '0;
`ifdef AXIS_UPSIZER_TLAST_EN
                last_q    <= last_in;
`endif
            end else if (m_axis_tready) begin
                out_vld_q <= 1'b0;
            end
        end
    end

    assign m_axis_tdata  = out_q;
    assign m_axis_tvalid = out_vld_q;

endmodule
